// File: rtl/delay_pkg.sv
// Shared types for the audio delay address controller.
package delay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/delay_addr_ctrl_if.sv
// Sample/RAM-command bundle between the delay controller, its RAM and the audio source.
// Handshake: a sample is accepted on every rising edge where en=1 and flush=0;
// there is no back-pressure, and out_valid marks each delay_out update for one cycle.
interface delay_addr_ctrl_if import delay_pkg::*; #(
    parameter int ADD_WIDTH = 9,
    parameter int D_WIDTH   = 8
);

    logic                 en;
    logic                 flush;
    logic [ADD_WIDTH-1:0] offset;
    logic [D_WIDTH-1:0]   mic_in;
    logic                 wr;
    logic                 rd;
    logic [ADD_WIDTH-1:0] wr_addr;
    logic [ADD_WIDTH-1:0] rd_addr;
    logic [D_WIDTH-1:0]   mic_signal;
    logic [D_WIDTH-1:0]   delayed_signal;
    logic [D_WIDTH-1:0]   delay_out;
    logic                 out_valid;
    logic                 primed;
    state_t               dbg_state;
    logic [ADD_WIDTH-1:0] dbg_off_q;

    modport slave (
        input  en, flush, offset, mic_in, delayed_signal,
        output wr, rd, wr_addr, rd_addr, mic_signal,
        output delay_out, out_valid, primed, dbg_state, dbg_off_q
    );

    modport master (
        output en, flush, offset, mic_in, delayed_signal,
        input  wr, rd, wr_addr, rd_addr, mic_signal,
        input  delay_out, out_valid, primed, dbg_state, dbg_off_q
    );

endinterface

// File: rtl/delay_addr_ctrl.sv
// Turns a sample strobe plus programmable delay into delay-RAM commands and
// presents the RAM's read data as a muted-until-primed delayed sample.
module delay_addr_ctrl import delay_pkg::*; #(
    parameter int ADD_WIDTH = 9,
    parameter int D_WIDTH   = 8
) (
    input logic              clk,
    input logic              rst_n,
    delay_addr_ctrl_if.slave bus
);

    localparam int                 N     = 2 ** ADD_WIDTH;
    localparam logic [ADD_WIDTH:0] N_VAL = (ADD_WIDTH + 1)'(N);

    state_t               r_state;
    state_t               w_state_next;
    logic [ADD_WIDTH-1:0] r_wptr;
    logic [ADD_WIDTH:0]   r_fill_cnt;
    logic [ADD_WIDTH-1:0] r_off_q;
    logic                 r_wr;
    logic                 r_rd;
    logic [ADD_WIDTH-1:0] r_wr_addr;
    logic [ADD_WIDTH-1:0] r_rd_addr;
    logic [D_WIDTH-1:0]   r_mic_signal;
    logic                 r_v_s1;
    logic                 r_v_s2;
    logic                 r_mute_s1;
    logic                 r_mute_s2;
    logic [D_WIDTH-1:0]   r_delay_out;
    logic                 r_out_valid;

    logic                 w_take;
    logic [ADD_WIDTH:0]   w_d_new;
    logic                 w_mute_new;

    // An offset of zero selects the full buffer depth.
    assign w_take     = bus.en & ~bus.flush;
    assign w_d_new    = (bus.offset == '0) ? N_VAL : {1'b0, bus.offset};
    assign w_mute_new = (r_fill_cnt < w_d_new);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The priming decision is taken per accepted sample, so a shrinking delay
    // that is already covered by history never leaves RUN.
    always_comb begin
        w_state_next = r_state;
        if (bus.flush) begin
            w_state_next = IDLE;
        end else if (bus.en) begin
            w_state_next = w_mute_new ? PRIME : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr       <= '0;
            r_fill_cnt   <= '0;
            r_off_q      <= '0;
            r_wr         <= 1'b0;
            r_rd         <= 1'b0;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_mic_signal <= '0;
            r_v_s1       <= 1'b0;
            r_v_s2       <= 1'b0;
            r_mute_s1    <= 1'b0;
            r_mute_s2    <= 1'b0;
            r_delay_out  <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            r_wr      <= w_take;
            r_rd      <= w_take;
            r_v_s1    <= w_take;
            r_mute_s1 <= w_mute_new;
            r_v_s2    <= r_v_s1 & ~bus.flush;
            r_mute_s2 <= r_mute_s1;
            r_out_valid <= r_v_s2 & ~bus.flush;
            if (r_v_s2 && !bus.flush) begin
                r_delay_out <= r_mute_s2 ? '0 : bus.delayed_signal;
            end
            if (bus.flush) begin
                r_wptr     <= '0;
                r_fill_cnt <= '0;
            end else if (bus.en) begin
                r_off_q      <= bus.offset;
                r_wr_addr    <= r_wptr;
                r_rd_addr    <= r_wptr - bus.offset;
                r_mic_signal <= bus.mic_in;
                r_wptr       <= r_wptr + ADD_WIDTH'(1);
                if (r_fill_cnt != N_VAL) begin
                    r_fill_cnt <= r_fill_cnt + (ADD_WIDTH + 1)'(1);
                end
            end
        end
    end

    assign bus.wr         = r_wr;
    assign bus.rd         = r_rd;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.rd_addr    = r_rd_addr;
    assign bus.mic_signal = r_mic_signal;
    assign bus.delay_out  = r_delay_out;
    assign bus.out_valid  = r_out_valid;
    assign bus.primed     = (r_state == RUN);
    assign bus.dbg_state  = r_state;
    assign bus.dbg_off_q  = r_off_q;

endmodule

// File: doc/delay_addr_ctrl.md
# delay_addr_ctrl

Sample-rate controller for the audio delay path. It sits directly upstream of the dual-port delay RAM. It turns a sample strobe and a programmable delay into RAM write/read commands and registered write data. It then consumes the RAM's registered read data and presents a muted-until-primed delayed sample with a valid pulse. Throughput is one sample per clock, with a fixed three-edge latency.

## Interface
Parameters:
- ADD_WIDTH, 9: RAM address width; buffer depth N = 2**ADD_WIDTH samples.
- D_WIDTH, 8: sample width.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  sample strobe; one sample per high cycle, may be high every cycle.
- flush  in  1  synchronous clear of buffer history.
- offset  in  ADD_WIDTH  requested delay in samples; 0 means N.
- mic_in  in  D_WIDTH  input sample, valid when en=1.
- wr  out  1  RAM write enable.
- rd  out  1  RAM read enable.
- wr_addr  out  ADD_WIDTH  RAM write address.
- rd_addr  out  ADD_WIDTH  RAM read address.
- mic_signal  out  D_WIDTH  RAM write data.
- delayed_signal  in  D_WIDTH  RAM registered read data, valid one edge after rd.
- delay_out  out  D_WIDTH  delayed sample; 0 while muted.
- out_valid  out  1  one-cycle pulse per delay_out update.
- primed  out  1  high in RUN state.

## Operation
- State: wptr (ADD_WIDTH, wraps N-1 to 0), fill_cnt (ADD_WIDTH+1, saturates at N), off_q (latched offset), FSM state_t {IDLE, PRIME, RUN}.
- D = (off_q == 0) ? N : off_q, computed at ADD_WIDTH+1 bits.
- At an en edge with flush=0:
  - latch off_q <= offset.
  - drive wr=rd=1, wr_addr=wptr, rd_addr=(wptr - offset) mod N, mic_signal=mic_in.
  - mute_s1 = (fill_cnt < D_new), where D_new is computed from the new offset.
  - wptr++, and fill_cnt++ (saturating).
- With rd_addr == wr_addr (offset 0), the RAM returns old data. That is exactly an N-sample delay.
- Any edge without en: wr=rd=0; addresses and mic_signal hold.
- FSM:
  - IDLE to PRIME on the first en.
  - PRIME to RUN once the post-update fill_cnt >= D.
  - RUN to PRIME when a new offset gives D > fill_cnt; history is kept, so there is no re-prime when shrinking the delay.
  - Any state to IDLE on flush.
- flush: wptr=0, fill_cnt=0, wr=rd=0, and in-flight valids cancelled. flush wins over a simultaneous en; that sample is dropped.
- Output stage: two edges after an en edge, delay_out <= mute ? 0 : delayed_signal, and out_valid=1 for one cycle.

## Timing
- en sampled at edge E0. wr/rd/addresses/mic_signal are visible after E0. The RAM acts at E1. delay_out and out_valid are visible after E2.
- The pipeline is fully pipelined: back-to-back en gives back-to-back out_valid.
- Reset values: wr=rd=0, wr_addr=rd_addr=0, mic_signal=0, delay_out=0, out_valid=0, primed=0, state IDLE, wptr=0, fill_cnt=0, off_q=0.
- Reset assertion mid-operation clears immediately. No out_valid appears for samples in flight.
- Address arithmetic is modulo N. The subtraction is done at ADD_WIDTH bits with wrap, never sign-extended.

## Structure
- Package delay_pkg holds the state_t enum {IDLE, PRIME, RUN}.
- No sub-module. The RAM is instantiated beside this block by the parent, not inside it.
- The mute flag and valid travel in a 2-stage shift alongside the RAM read.

## Test plan
- Reset; offset=4; ramp 1,2,3… with en every 4 cycles -> samples 1–4 give delay_out=0, primed=0. Sample 5 gives delay_out=1, and primed rises at sample 5's E0.
- offset=0 with a ramp mod 256 -> the first 512 outputs are 0. Output 513 equals input 1, and output k equals input k-512 thereafter.
- Wrap: offset=3 at wptr=1 -> rd_addr=510, wr_addr=1. Output matches the sample written at address 510.
- Offset change:
  - 4 to 10 after 6 samples -> primed falls, mute applies until fill_cnt=10, and the 11th sample is unmuted.
  - Then 10 to 2 -> primed stays 1 with no muted output.
- en every cycle for 20 cycles -> 20 consecutive out_valid pulses, each exactly 2 edges after its wr/rd.
- Mid-run cases:
  - rst_n low mid-run -> all outputs 0 asynchronously, and the next sample re-primes.
  - flush together with en -> no wr, no out_valid for that sample, and wptr restarts at 0.
